data_memory_ctrl: RTL and testbench
===================================

Name: data_memory_ctrl

Overview:
- Next-generation RV32 data memory for the single-cycle/multi-cycle CPU datapath.
- Adds four capabilities:
  - a valid/ready request port with a parametrised access latency;
  - byte, halfword and word loads/stores selected by funct3, with sign or zero extension;
  - misaligned and out-of-range error reporting;
  - a sequential memory-clear engine that runs after reset.

Parameters:
- MEM_DEPTH, 16384: number of 32-bit words; must be a power of two, at least 2.
- LATENCY, 1: cycles from request acceptance to response (1..8).
- CLEAR_ON_RESET, 1: 1 = zero the whole array word-by-word after reset; 0 = skip clearing.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request; high only in IDLE.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned in the low bits.
- req_funct3  input  3  access type, RV32 load/store encoding.
- resp_valid  output  1  one-cycle response pulse.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  request rejected: misaligned, out of range or illegal funct3.
- init_done  output  1  clearing complete; stays high until the next reset.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset: at any rising edge with reset==0:
  - state<=CLEAR, or IDLE when CLEAR_ON_RESET==0;
  - clr_idx<=0, resp_valid<=0, resp_rdata<=0, resp_err<=0;
  - init_done<=0 (CLEAR_ON_RESET==1) or 1 (CLEAR_ON_RESET==0).
  - Any in-flight request is dropped: no response, and an uncommitted store is not written.
- States: CLEAR, IDLE, WAIT, RESP. req_ready = (state==IDLE), decoded combinationally.
- CLEAR: each edge with reset==1 writes mem[clr_idx]=0 and increments clr_idx.
  - On the edge that writes index MEM_DEPTH-1: state<=IDLE, init_done<=1.
  - First request can be accepted MEM_DEPTH cycles after reset release.
- IDLE: on an edge with req_valid && req_ready, latch write, addr, wdata and funct3.
  - Go to WAIT with wait_cnt<=LATENCY-1 when LATENCY>1; otherwise go to RESP.
- WAIT: decrement wait_cnt; when it reaches 1, go to RESP on that edge. No memory access occurs in WAIT.
- Commit edge: the edge entering RESP.
  - Loads read the array on this edge.
  - Stores write the array on this edge.
  - resp_valid<=1 and resp_rdata/resp_err are registered on this edge.
- RESP: resp_valid is high for exactly one cycle; next edge: state<=IDLE, resp_valid<=0.
  - Total occupancy is LATENCY+1 cycles per request; no back-pressure on the response side.
- Address decode:
  - word index = addr[log2(MEM_DEPTH)+1:2];
  - any set bit in addr[31:log2(MEM_DEPTH)+2] gives err.
- funct3 decode:
  - legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU;
  - legal stores: 000 SB, 001 SH, 010 SW;
  - anything else gives err.
- Alignment: H with addr[0]==1 gives err; W with addr[1:0]!=0 gives err.
- On err: no array change, resp_rdata=0, resp_err=1.
- Stores (lane = addr[1:0]):
  - SB writes wdata[7:0] into byte lane addr[1:0];
  - SH writes wdata[15:0] into lanes {addr[1],0} and {addr[1],1};
  - SW writes the full word;
  - unselected bytes are preserved;
  - resp_rdata=0, resp_err=0.
- Loads: select the byte or halfword by addr[1:0] (little-endian).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unmodified.
- req_* inputs are ignored outside IDLE.
- req_valid during CLEAR is not accepted, because req_ready is 0.

Test Plan:
- Clear: MEM_DEPTH=16, CLEAR_ON_RESET=1, preload junk, reset low 2 cycles then high -> req_ready=0 and init_done=0 for 16 cycles, then both 1; LW from every word returns 0.
- Byte/halfword stores:
  - SW 0x11223344 @0x8, then SB 0xAB @0xA, then LW @0x8 -> 0x11AB3344;
  - SH 0xBEEF @0xA, then LW -> 0xBEEF3344.
- Extension: word 0x80FF7F01 @0x4:
  - LB @0x6 -> 0xFFFFFFFF;
  - LBU @0x7 -> 0x00000080;
  - LH @0x6 -> 0xFFFF80FF;
  - LHU @0x4 -> 0x00007F01.
- Errors (MEM_DEPTH=16):
  - LW @0x2, SH @0x1, LW @0x40, funct3=011 -> each gives resp_err=1, rdata=0;
  - a following LW of the targeted words shows them unchanged.
- Latency: LATENCY=4, req_valid held high continuously -> resp_valid exactly 4 cycles after each accept edge, ready low 4 cycles, accepts spaced 5 cycles apart.
- Reset mid-operation: LATENCY=4, SW 0xDEADBEEF @0x0 accepted, reset low 2 cycles later -> no resp_valid; after re-clear, LW @0x0 returns 0.

Source files
------------

// File: rtl/data_memory_ctrl.sv
// RV32 data memory with a valid/ready request port, configurable access latency,
// byte/halfword/word accesses with extension, error reporting and a post-reset clear engine.
module data_memory_ctrl #(
  parameter int unsigned MEM_DEPTH      = 16384,
  parameter int unsigned LATENCY        = 1,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        init_done
);

  localparam int unsigned AW   = $clog2(MEM_DEPTH);
  localparam bit          LAT1 = (LATENCY <= 1);

  typedef enum logic [1:0] {StClear, StIdle, StWait, StResp} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] clr_idx_q, clr_idx_d;
  logic [3:0]    wait_cnt_q, wait_cnt_d;
  logic          lat_write_q, lat_write_d;
  logic [31:0]   lat_addr_q, lat_addr_d;
  logic [31:0]   lat_wdata_q, lat_wdata_d;
  logic [2:0]    lat_funct3_q, lat_funct3_d;
  logic          resp_valid_q, resp_valid_d;
  logic [31:0]   resp_rdata_q, resp_rdata_d;
  logic          resp_err_q, resp_err_d;
  logic          init_done_q, init_done_d;

  logic [31:0]   mem_q [MEM_DEPTH];

  logic          accept, commit, clr_last;
  logic          cur_write;
  logic [31:0]   cur_addr, cur_wdata;
  logic [2:0]    cur_funct3;
  logic [AW-1:0] idx;
  logic          addr_err, f3_err, align_err, err;
  logic [31:0]   rd_word, wr_word, wr_rep, load_data;
  logic [3:0]    be;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;

  assign accept   = req_valid && req_ready;
  assign clr_last = (clr_idx_q == AW'(MEM_DEPTH - 1));
  assign commit   = (state_q == StIdle && accept && LAT1) ||
                    (state_q == StWait && wait_cnt_q == 4'd1);

  // With single-cycle latency the commit edge is the accept edge, so use the live request.
  assign cur_write  = (state_q == StIdle) ? req_write  : lat_write_q;
  assign cur_addr   = (state_q == StIdle) ? req_addr   : lat_addr_q;
  assign cur_wdata  = (state_q == StIdle) ? req_wdata  : lat_wdata_q;
  assign cur_funct3 = (state_q == StIdle) ? req_funct3 : lat_funct3_q;

  assign idx      = cur_addr[AW+1:2];
  assign addr_err = ((cur_addr >> (AW + 2)) != 32'd0);
  assign rd_word  = mem_q[idx];
  assign byte_sel = rd_word[{cur_addr[1:0], 3'b000} +: 8];
  assign half_sel = rd_word[{cur_addr[1], 4'b0000} +: 16];

  always_comb begin
    f3_err = 1'b0;
    case (cur_funct3)
      3'b000, 3'b001, 3'b010: f3_err = 1'b0;
      3'b100, 3'b101:         f3_err = cur_write;
      default:                f3_err = 1'b1;
    endcase
    align_err = ((cur_funct3[1:0] == 2'b01) && cur_addr[0]) ||
                ((cur_funct3[1:0] == 2'b10) && (cur_addr[1:0] != 2'b00));
    err = addr_err || f3_err || align_err;
  end

  always_comb begin
    load_data = rd_word;
    case (cur_funct3)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_data = {24'd0, byte_sel};
      3'b101:  load_data = {16'd0, half_sel};
      default: load_data = rd_word;
    endcase
  end

  always_comb begin
    be     = 4'b1111;
    wr_rep = cur_wdata;
    case (cur_funct3[1:0])
      2'b00: begin
        be     = 4'b0001 << cur_addr[1:0];
        wr_rep = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        be     = cur_addr[1] ? 4'b1100 : 4'b0011;
        wr_rep = {2{cur_wdata[15:0]}};
      end
      default: begin
        be     = 4'b1111;
        wr_rep = cur_wdata;
      end
    endcase
    wr_word = rd_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) wr_word[8*i +: 8] = wr_rep[8*i +: 8];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= (CLEAR_ON_RESET != 0) ? StClear : StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StClear: if (clr_last) state_d = StIdle;
      StIdle:  if (accept) state_d = LAT1 ? StResp : StWait;
      StWait:  if (wait_cnt_q == 4'd1) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode
  always_comb begin
    req_ready = (state_q == StIdle);
  end

  always_comb begin
    clr_idx_d    = clr_idx_q;
    wait_cnt_d   = wait_cnt_q;
    lat_write_d  = lat_write_q;
    lat_addr_d   = lat_addr_q;
    lat_wdata_d  = lat_wdata_q;
    lat_funct3_d = lat_funct3_q;
    resp_valid_d = commit;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    init_done_d  = init_done_q;
    if (state_q == StClear) begin
      clr_idx_d = clr_idx_q + 1'b1;
      if (clr_last) init_done_d = 1'b1;
    end
    if (accept) begin
      lat_write_d  = req_write;
      lat_addr_d   = req_addr;
      lat_wdata_d  = req_wdata;
      lat_funct3_d = req_funct3;
      wait_cnt_d   = 4'(LATENCY - 1);
    end else if (state_q == StWait) begin
      wait_cnt_d = wait_cnt_q - 4'd1;
    end
    if (commit) begin
      resp_err_d   = err;
      resp_rdata_d = (err || cur_write) ? 32'd0 : load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      clr_idx_q    <= '0;
      wait_cnt_q   <= '0;
      lat_write_q  <= 1'b0;
      lat_addr_q   <= '0;
      lat_wdata_q  <= '0;
      lat_funct3_q <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      init_done_q  <= (CLEAR_ON_RESET == 0);
    end else begin
      clr_idx_q    <= clr_idx_d;
      wait_cnt_q   <= wait_cnt_d;
      lat_write_q  <= lat_write_d;
      lat_addr_q   <= lat_addr_d;
      lat_wdata_q  <= lat_wdata_d;
      lat_funct3_q <= lat_funct3_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      init_done_q  <= init_done_d;
    end
  end

  // Array has no reset; nothing is written on a reset edge, so in-flight stores are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (state_q == StClear)                 mem_q[clr_idx_q] <= 32'd0;
      else if (commit && cur_write && !err)   mem_q[idx]       <= wr_word;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign init_done  = init_done_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench: instance 0 has LATENCY=1, instance 1 has LATENCY=4, both MEM_DEPTH=16.
module tb_data_memory_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst_n, req_valid, req_write, req_ready, resp_valid, resp_err, init_done;
  logic [1:0][31:0] req_addr, req_wdata, resp_rdata;
  logic [1:0][2:0]  req_funct3;

  int n_cmp  = 0;
  int n_fail = 0;

  data_memory_ctrl #(.MEM_DEPTH(16), .LATENCY(1), .CLEAR_ON_RESET(1)) u_dut_l1 (
    .clk        (clk),
    .reset      (rst_n[0]),
    .req_valid  (req_valid[0]),
    .req_ready  (req_ready[0]),
    .req_write  (req_write[0]),
    .req_addr   (req_addr[0]),
    .req_wdata  (req_wdata[0]),
    .req_funct3 (req_funct3[0]),
    .resp_valid (resp_valid[0]),
    .resp_rdata (resp_rdata[0]),
    .resp_err   (resp_err[0]),
    .init_done  (init_done[0])
  );

  data_memory_ctrl #(.MEM_DEPTH(16), .LATENCY(4), .CLEAR_ON_RESET(1)) u_dut_l4 (
    .clk        (clk),
    .reset      (rst_n[1]),
    .req_valid  (req_valid[1]),
    .req_ready  (req_ready[1]),
    .req_write  (req_write[1]),
    .req_addr   (req_addr[1]),
    .req_wdata  (req_wdata[1]),
    .req_funct3 (req_funct3[1]),
    .resp_valid (resp_valid[1]),
    .resp_rdata (resp_rdata[1]),
    .resp_err   (resp_err[1]),
    .init_done  (init_done[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Two reset edges, then check that clearing holds off requests for exactly 16 cycles.
  task automatic do_reset(input int b);
    @(negedge clk);
    rst_n[b]     = 1'b0;
    req_valid[b] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk1("rst_ready", req_ready[b], 1'b0);
    chk1("rst_init", init_done[b], 1'b0);
    chk1("rst_resp_valid", resp_valid[b], 1'b0);
    chk("rst_rdata", resp_rdata[b], 32'd0);
    chk1("rst_err", resp_err[b], 1'b0);
    rst_n[b] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      chk1("clr_ready", req_ready[b], 1'b0);
      chk1("clr_init", init_done[b], 1'b0);
      chk1("clr_resp_valid", resp_valid[b], 1'b0);
    end
    @(negedge clk);
    chk1("clr_done_ready", req_ready[b], 1'b1);
    chk1("clr_done_init", init_done[b], 1'b1);
  endtask

  task automatic do_req(input int b, input logic w, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rd, output logic er);
    logic got;
    got = 1'b0;
    rd  = 'x;
    er  = 1'bx;
    @(negedge clk);
    req_write[b]  = w;
    req_funct3[b] = f3;
    req_addr[b]   = addr;
    req_wdata[b]  = wdata;
    req_valid[b]  = 1'b1;
    for (int i = 0; i < 50 && !req_ready[b]; i++) @(negedge clk);
    @(negedge clk);
    req_valid[b] = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (resp_valid[b]) begin
        got = 1'b1;
        rd  = resp_rdata[b];
        er  = resp_err[b];
      end else begin
        @(negedge clk);
      end
    end
    n_cmp++;
    assert (got) else begin
      n_fail++;
      $error("FAIL resp_timeout: observed no resp_valid expected resp_valid=1");
    end
  endtask

  task automatic ld(input int b, input logic [2:0] f3, input logic [31:0] addr,
                    input logic [31:0] exp, input string tag);
    logic [31:0] rd;
    logic        er;
    do_req(b, 1'b0, f3, addr, 32'd0, rd, er);
    chk(tag, rd, exp);
    chk1({tag, "_err"}, er, 1'b0);
  endtask

  task automatic st(input int b, input logic [2:0] f3, input logic [31:0] addr,
                    input logic [31:0] wdata, input string tag);
    logic [31:0] rd;
    logic        er;
    do_req(b, 1'b1, f3, addr, wdata, rd, er);
    chk(tag, rd, 32'd0);
    chk1({tag, "_err"}, er, 1'b0);
  endtask

  task automatic bad(input int b, input logic w, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input string tag);
    logic [31:0] rd;
    logic        er;
    do_req(b, w, f3, addr, wdata, rd, er);
    chk(tag, rd, 32'd0);
    chk1({tag, "_err"}, er, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 2'b00;
    req_valid  = 2'b00;
    req_write  = 2'b00;
    req_addr   = '0;
    req_wdata  = '0;
    req_funct3 = '0;

    // Clear engine: fill with junk, reset, every word reads back zero.
    do_reset(0);
    for (int i = 0; i < 16; i++) st(0, 3'b010, 32'(i * 4), 32'hA5A5_0000 | 32'(i), "junk_sw");
    ld(0, 3'b010, 32'h14, 32'hA5A5_0005, "junk_lw");
    do_reset(0);
    for (int i = 0; i < 16; i++) ld(0, 3'b010, 32'(i * 4), 32'd0, "clr_lw");

    // Byte and halfword stores preserve unselected lanes.
    st(0, 3'b010, 32'h8, 32'h1122_3344, "sw_8");
    st(0, 3'b000, 32'hA, 32'h0000_00AB, "sb_a");
    ld(0, 3'b010, 32'h8, 32'h11AB_3344, "lw_after_sb");
    st(0, 3'b001, 32'hA, 32'h0000_BEEF, "sh_a");
    ld(0, 3'b010, 32'h8, 32'hBEEF_3344, "lw_after_sh");

    // Sign and zero extension.
    st(0, 3'b010, 32'h4, 32'h80FF_7F01, "sw_4");
    ld(0, 3'b000, 32'h6, 32'hFFFF_FFFF, "lb_6");
    ld(0, 3'b100, 32'h7, 32'h0000_0080, "lbu_7");
    ld(0, 3'b001, 32'h6, 32'hFFFF_80FF, "lh_6");
    ld(0, 3'b101, 32'h4, 32'h0000_7F01, "lhu_4");
    ld(0, 3'b000, 32'h5, 32'h0000_007F, "lb_5");

    // Error cases leave the array untouched.
    bad(0, 1'b0, 3'b010, 32'h2, 32'd0, "err_lw_mis");
    bad(0, 1'b1, 3'b001, 32'h1, 32'h0000_1234, "err_sh_mis");
    ld(0, 3'b010, 32'h0, 32'd0, "lw0_after_sh_mis");
    bad(0, 1'b0, 3'b010, 32'h40, 32'd0, "err_lw_range");
    bad(0, 1'b1, 3'b010, 32'h40, 32'hFFFF_FFFF, "err_sw_range");
    ld(0, 3'b010, 32'h0, 32'd0, "lw0_after_sw_range");
    bad(0, 1'b1, 3'b011, 32'h8, 32'hFFFF_FFFF, "err_f3_011");
    bad(0, 1'b1, 3'b100, 32'h8, 32'hFFFF_FFFF, "err_store_f3_100");
    bad(0, 1'b0, 3'b110, 32'h4, 32'd0, "err_load_f3_110");
    ld(0, 3'b010, 32'h8, 32'hBEEF_3344, "lw8_after_errs");

    // LATENCY=4 with req_valid held: accepts every 5 cycles, response in the 4th cycle after.
    do_reset(1);
    req_write[1]  = 1'b0;
    req_funct3[1] = 3'b010;
    req_addr[1]   = 32'h0;
    req_valid[1]  = 1'b1;
    for (int n = 1; n <= 15; n++) begin
      @(negedge clk);
      chk1("lat_ready", req_ready[1], (n % 5) == 0);
      chk1("lat_resp_valid", resp_valid[1], (n % 5) == 4);
    end
    req_valid[1] = 1'b0;
    st(1, 3'b010, 32'h8, 32'hCAFE_F00D, "l4_sw");
    ld(1, 3'b010, 32'h8, 32'hCAFE_F00D, "l4_lw");
    ld(1, 3'b101, 32'hA, 32'h0000_CAFE, "l4_lhu");

    // Reset two cycles after accepting a store: no response ever appears.
    @(negedge clk);
    chk1("mid_ready", req_ready[1], 1'b1);
    req_write[1]  = 1'b1;
    req_funct3[1] = 3'b010;
    req_addr[1]   = 32'h0;
    req_wdata[1]  = 32'hDEAD_BEEF;
    req_valid[1]  = 1'b1;
    @(negedge clk);
    chk1("mid_accepted", req_ready[1], 1'b0);
    req_valid[1] = 1'b0;
    do_reset(1);
    ld(1, 3'b010, 32'h0, 32'd0, "mid_lw0");
    ld(1, 3'b010, 32'h8, 32'd0, "mid_lw8");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
